cordic_iter_ctrl: RTL and testbench

//  Sequencer for the iterative CORDIC engine. Accepts one operation per request,

---
 rtl/cordic_pkg.sv | 17 +
 rtl/cordic_step_counter.sv | 29 ++
 rtl/cordic_iter_ctrl.sv | 116 +++++++++++
 tb/tb_cordic_iter_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared types for the iterative CORDIC engine: controller state encoding and
// operating-mode constants used by the controller, datapath and bench.
package cordic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_PREROT = 3'd2,
    ST_ITER   = 3'd3,
    ST_SCALE  = 3'd4,
    ST_DONE   = 3'd5
  } cordic_state_e;

  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_VEC = 1'b1;

endpackage

// File: rtl/cordic_step_counter.sv
// Micro-rotation step index: cleared when an operation is accepted, advanced
// once per ITER cycle, and saturating at ITER-1 where last is raised.
module cordic_step_counter #(
  parameter int ITER  = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [IDX_W-1:0] cnt,
  output logic             last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ITER - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !last) begin
      cnt <= cnt + IDX_W'(1);
    end
  end

  assign last = (cnt == LAST_IDX);

endmodule

// File: rtl/cordic_iter_ctrl.sv
// Sequencer for the iterative CORDIC datapath: load, pre-rotation, ITER
// micro-rotations steered by live sign feedback, gain scaling, then a held response.
module cordic_iter_ctrl
  import cordic_pkg::*;
#(
  parameter int ITER  = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_mode,
  input  logic             flush,
  input  logic             fb_x_neg,
  input  logic             fb_y_neg,
  input  logic             fb_z_neg,
  input  logic             fb_z_big,
  output logic             dp_load,
  output logic             dp_prerot,
  output logic             dp_step,
  output logic             dp_dir,
  output logic [IDX_W-1:0] dp_shift,
  output logic             dp_scale,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             busy
);

  if (ITER < 1 || ITER > (2 ** IDX_W)) begin : g_bad_iter
    $error("cordic_iter_ctrl: ITER must lie in 1..2**IDX_W");
  end

  cordic_state_e    state;
  cordic_state_e    state_nxt;
  logic             mode_q;
  logic             accept;
  logic [IDX_W-1:0] step_idx;
  logic             step_last;

  // A flush in IDLE suppresses acceptance so an aborted request cannot slip in.
  assign accept = (state == ST_IDLE) && req_valid && !flush;

  cordic_step_counter #(
    .ITER  (ITER),
    .IDX_W (IDX_W)
  ) u_step_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (state == ST_ITER),
    .cnt   (step_idx),
    .last  (step_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      mode_q <= MODE_ROT;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mode_q <= req_mode;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (state != ST_IDLE && flush) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:   if (accept) state_nxt = ST_LOAD;
        ST_LOAD:   state_nxt = ST_PREROT;
        ST_PREROT: state_nxt = ST_ITER;
        ST_ITER:   if (step_last) state_nxt = ST_SCALE;
        ST_SCALE:  state_nxt = ST_DONE;
        ST_DONE:   if (rsp_ready) state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // Strobes decode registered state; only direction and pre-rotation look at live feedback.
  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b1;
    dp_load   = 1'b0;
    dp_prerot = 1'b0;
    dp_step   = 1'b0;
    dp_dir    = 1'b0;
    dp_shift  = '0;
    dp_scale  = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      ST_LOAD:   dp_load = 1'b1;
      ST_PREROT: dp_prerot = (mode_q == MODE_VEC) ? fb_x_neg : fb_z_big;
      ST_ITER: begin
        dp_step  = 1'b1;
        dp_shift = step_idx;
        dp_dir   = (mode_q == MODE_VEC) ? fb_y_neg : !fb_z_neg;
      end
      ST_SCALE:  dp_scale = 1'b1;
      ST_DONE:   rsp_valid = 1'b1;
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Self-checking bench for cordic_iter_ctrl: an ITER=16 and an ITER=1 instance
// checked cycle by cycle against a timeline model of the operation sequence.
module tb_cordic_iter_ctrl;
  import cordic_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fb_x_neg, fb_y_neg, fb_z_neg, fb_z_big;

  logic       req_valid, req_ready, req_mode, flush, rsp_ready, rsp_valid, busy;
  logic       dp_load, dp_prerot, dp_step, dp_dir, dp_scale;
  logic [3:0] dp_shift;

  logic       req_valid1, req_ready1, req_mode1, flush1, rsp_ready1, rsp_valid1, busy1;
  logic       dp_load1, dp_prerot1, dp_step1, dp_dir1, dp_scale1;
  logic [3:0] dp_shift1;

  int checks = 0;
  int passes = 0;

  localparam logic [11:0] IDLE_VEC = 12'b0000_0000_0010;

  always #5 clk = ~clk;

  cordic_iter_ctrl #(.ITER(16), .IDX_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .flush(flush), .fb_x_neg(fb_x_neg), .fb_y_neg(fb_y_neg),
    .fb_z_neg(fb_z_neg), .fb_z_big(fb_z_big), .dp_load(dp_load), .dp_prerot(dp_prerot),
    .dp_step(dp_step), .dp_dir(dp_dir), .dp_shift(dp_shift), .dp_scale(dp_scale),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .busy(busy)
  );

  cordic_iter_ctrl #(.ITER(1), .IDX_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_mode(req_mode1), .flush(flush1), .fb_x_neg(fb_x_neg), .fb_y_neg(fb_y_neg),
    .fb_z_neg(fb_z_neg), .fb_z_big(fb_z_big), .dp_load(dp_load1), .dp_prerot(dp_prerot1),
    .dp_step(dp_step1), .dp_dir(dp_dir1), .dp_shift(dp_shift1), .dp_scale(dp_scale1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .busy(busy1)
  );

  // Expected outputs for cycle c after acceptance (accept edge = cycle 0).
  function automatic logic [11:0] model(input int c, input int n, input bit mode,
                                        input bit xn, input bit yn, input bit zn, input bit zb);
    logic ld, pr, st, dr, sc, rv;
    logic [3:0] sh;
    ld = (c == 1);
    pr = (c == 2) && (mode ? xn : zb);
    st = (c >= 3) && (c <= n + 2);
    sh = st ? 4'(c - 3) : 4'd0;
    dr = st && (mode ? yn : !zn);
    sc = (c == n + 3);
    rv = (c >= n + 4);
    return {ld, pr, st, dr, sh, sc, rv, 1'b0, 1'b1};
  endfunction

  function automatic logic [11:0] obs16();
    return {dp_load, dp_prerot, dp_step, dp_dir, dp_shift, dp_scale, rsp_valid, req_ready, busy};
  endfunction

  function automatic logic [11:0] obs1();
    return {dp_load1, dp_prerot1, dp_step1, dp_dir1, dp_shift1, dp_scale1, rsp_valid1, req_ready1, busy1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_fb(input int fbsel, inout bit zt);
    fb_x_neg = 1'($urandom_range(0, 1));
    fb_y_neg = 1'($urandom_range(0, 1));
    fb_z_neg = 1'($urandom_range(0, 1));
    fb_z_big = 1'($urandom_range(0, 1));
    if (fbsel == 1) begin
      fb_z_big = 1'b1;
      fb_z_neg = zt;
      zt = !zt;
    end else if (fbsel == 2) begin
      fb_x_neg = 1'b0;
      fb_y_neg = 1'b1;
    end
  endtask

  // One ITER=16 operation. fbsel: 0 random, 1 z toggling with z_big, 2 x=0/y=1.
  task automatic run_op(input bit mode, input int fbsel, input int hold,
                        input int flush_at, input bit keep_req, input string tag);
    int n = 16;
    int last_c;
    bit zt;
    logic [11:0] exp_v, got;
    last_c = n + 4 + hold;
    zt = 1'($urandom_range(0, 1));
    req_mode = mode; req_valid = 1'b1; rsp_ready = 1'b0; flush = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) $display("FAIL %s accept: req_ready=%b required 1", tag, req_ready);
    else passes++;
    tick();
    req_valid = 1'b0;
    req_mode  = 1'($urandom_range(0, 1));
    for (int c = 1; c <= last_c; c++) begin
      drive_fb(fbsel, zt);
      req_valid = keep_req && (c >= n + 4);
      rsp_ready = (c == last_c);
      flush     = (c == flush_at);
      #1;
      exp_v = model(c, n, mode, fb_x_neg, fb_y_neg, fb_z_neg, fb_z_big);
      got   = obs16();
      checks++;
      if (got !== exp_v) $display("FAIL %s cycle %0d: got %b required %b", tag, c, got, exp_v);
      else passes++;
      tick();
      if (c == flush_at) break;
    end
    flush = 1'b0; rsp_ready = 1'b0;
    got = obs16();
    checks++;
    if (got !== IDLE_VEC) $display("FAIL %s return-to-idle: got %b required %b", tag, got, IDLE_VEC);
    else passes++;
    if (keep_req) begin
      tick();
      req_valid = 1'b0;
      checks++;
      if (dp_load !== 1'b1 || busy !== 1'b1)
        $display("FAIL %s waiting request: load=%b busy=%b required 1 1", tag, dp_load, busy);
      else passes++;
      flush = 1'b1;
      tick();
      flush = 1'b0;
    end
    req_valid = 1'b0;
  endtask

  task automatic expect_quiet(input int cycles, input string tag);
    int bad = 0;
    for (int i = 0; i < cycles; i++) begin
      if (obs16() !== IDLE_VEC) bad++;
      tick();
    end
    checks++;
    if (bad != 0) $display("FAIL %s quiet: %0d non-idle cycles, required 0", tag, bad);
    else passes++;
  endtask

  task automatic test_reset();
    logic [11:0] got;
    got = obs16();
    checks++;
    if (got !== IDLE_VEC) $display("FAIL reset16: got %b required %b", got, IDLE_VEC);
    else passes++;
    got = obs1();
    checks++;
    if (got !== IDLE_VEC) $display("FAIL reset1: got %b required %b", got, IDLE_VEC);
    else passes++;
    // Reset mid-ITER at step 5.
    req_mode = MODE_ROT; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int c = 1; c < 8; c++) tick();
    checks++;
    if (dp_step !== 1'b1 || dp_shift !== 4'd5)
      $display("FAIL reset_mid setup: step=%b shift=%0d required 1 5", dp_step, dp_shift);
    else passes++;
    rst_n = 1'b0;
    #1;
    got = obs16();
    checks++;
    if (got !== IDLE_VEC) $display("FAIL reset_mid async: got %b required %b", got, IDLE_VEC);
    else passes++;
    tick();
    got = obs16();
    checks++;
    if (got !== IDLE_VEC) $display("FAIL reset_mid held: got %b required %b", got, IDLE_VEC);
    else passes++;
    rst_n = 1'b1;
    expect_quiet(30, "reset_mid");
  endtask

  task automatic test_rotation();
    run_op(MODE_ROT, 1, 0, 0, 1'b0, "rotation");
  endtask

  task automatic test_vectoring();
    run_op(MODE_VEC, 2, 0, 0, 1'b0, "vectoring");
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++)
      run_op(1'($urandom_range(0, 1)), 0, $urandom_range(0, 3), 0, 1'b0, "random");
  endtask

  task automatic test_back_to_back();
    run_op(MODE_ROT, 0, 10, 0, 1'b1, "backpressure");
  endtask

  task automatic test_flush();
    run_op(MODE_VEC, 0, 0, 10, 1'b0, "flush_iter");
    expect_quiet(22, "flush_iter");
    run_op(MODE_ROT, 0, 2, 22, 1'b0, "flush_done");
    expect_quiet(5, "flush_done");
    req_valid = 1'b1; flush = 1'b1;
    tick();
    req_valid = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || dp_load !== 1'b0)
      $display("FAIL flush_idle: busy=%b load=%b required 0 0", busy, dp_load);
    else passes++;
  endtask

  task automatic test_iter1(input bit mode);
    logic [11:0] exp_v, got;
    int steps = 0;
    bit zt = 1'b0;
    req_mode1 = mode; req_valid1 = 1'b1; rsp_ready1 = 1'b0; flush1 = 1'b0;
    tick();
    req_valid1 = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      drive_fb(0, zt);
      rsp_ready1 = (c == 5);
      #1;
      exp_v = model(c, 1, mode, fb_x_neg, fb_y_neg, fb_z_neg, fb_z_big);
      got   = obs1();
      if (dp_step1 === 1'b1) steps++;
      checks++;
      if (got !== exp_v) $display("FAIL iter1 cycle %0d: got %b required %b", c, got, exp_v);
      else passes++;
      tick();
    end
    rsp_ready1 = 1'b0;
    checks++;
    if (steps != 1 || obs1() !== IDLE_VEC)
      $display("FAIL iter1 steps: %0d steps final %b required 1 steps %b", steps, obs1(), IDLE_VEC);
    else passes++;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_mode = 1'b0; flush = 1'b0; rsp_ready = 1'b0;
    req_valid1 = 1'b0; req_mode1 = 1'b0; flush1 = 1'b0; rsp_ready1 = 1'b0;
    fb_x_neg = 1'b0; fb_y_neg = 1'b0; fb_z_neg = 1'b0; fb_z_big = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_rotation();
    test_vectoring();
    test_random();
    test_back_to_back();
    test_flush();
    test_iter1(MODE_ROT);
    test_iter1(MODE_VEC);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
